// File: rtl/glb_load_scheduler_if.sv
// rtl/glb_load_scheduler_if.sv - load request, DRAM stream and GLB write bus bundle
interface glb_load_scheduler_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Load request and per-buffer word counts
  logic              start;
  logic [ADDR_W:0]   cfg_bias_words;
  logic [ADDR_W:0]   cfg_weight_words;
  logic [ADDR_W:0]   cfg_ifmap_words;
  logic              hold;

  // DRAM input stream
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  // GLB write port
  logic              bias_wen;
  logic              weight_wen;
  logic              ifmap_wen;
  logic [ADDR_W-1:0] glb_addr;
  logic [DATA_W-1:0] glb_wdata;

  // Status
  logic              busy;
  logic              load_done;

  // Requester / stream source side
  modport master (
    output start, cfg_bias_words, cfg_weight_words, cfg_ifmap_words, hold,
    output in_valid, in_data,
    input  in_ready,
    input  bias_wen, weight_wen, ifmap_wen, glb_addr, glb_wdata,
    input  busy, load_done
  );

  // Scheduler side
  modport slave (
    input  start, cfg_bias_words, cfg_weight_words, cfg_ifmap_words, hold,
    input  in_valid, in_data,
    output in_ready,
    output bias_wen, weight_wen, ifmap_wen, glb_addr, glb_wdata,
    output busy, load_done
  );
endinterface

// File: rtl/glb_load_scheduler.sv
// rtl/glb_load_scheduler.sv - sequences the DRAM stream into bias, weight and ifmap GLBs
module glb_load_scheduler #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  glb_load_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LD_BIAS,
    LD_WEIGHT,
    LD_IFMAP,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   cnt_bias;
  logic [ADDR_W:0]   cnt_weight;
  logic [ADDR_W:0]   cnt_ifmap;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] addr_cnt;

  logic              bias_wen_q;
  logic              weight_wen_q;
  logic              ifmap_wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              loading;
  logic              xfer;
  logic              last_word;
  state_t            first_phase;
  state_t            after_phase;
  logic [ADDR_W:0]   first_count;
  logic [ADDR_W:0]   after_count;

  // First phase with a nonzero count; callers zero out phases already passed
  function automatic state_t first_nonzero(input logic [ADDR_W:0] b,
                                           input logic [ADDR_W:0] w,
                                           input logic [ADDR_W:0] i);
    if (b != '0)      return LD_BIAS;
    else if (w != '0) return LD_WEIGHT;
    else if (i != '0) return LD_IFMAP;
    else              return DONE;
  endfunction

  // Word count that belongs to a given phase
  function automatic logic [ADDR_W:0] count_of(input state_t s,
                                               input logic [ADDR_W:0] b,
                                               input logic [ADDR_W:0] w,
                                               input logic [ADDR_W:0] i);
    case (s)
      LD_BIAS:   return b;
      LD_WEIGHT: return w;
      LD_IFMAP:  return i;
      default:   return '0;
    endcase
  endfunction

  assign loading   = (state == LD_BIAS) || (state == LD_WEIGHT) || (state == LD_IFMAP);
  assign xfer      = bus.in_valid && loading && !bus.hold;
  assign last_word = (remaining == (ADDR_W+1)'(1));

  // Phase selection: on start from the raw config, on phase exit from the latched counts
  always_comb begin
    first_phase = first_nonzero(bus.cfg_bias_words, bus.cfg_weight_words, bus.cfg_ifmap_words);
    first_count = count_of(first_phase, bus.cfg_bias_words, bus.cfg_weight_words,
                           bus.cfg_ifmap_words);
    after_phase = DONE;
    case (state)
      LD_BIAS:   after_phase = first_nonzero('0, cnt_weight, cnt_ifmap);
      LD_WEIGHT: after_phase = first_nonzero('0, '0, cnt_ifmap);
      default:   after_phase = DONE;
    endcase
    after_count = count_of(after_phase, cnt_bias, cnt_weight, cnt_ifmap);
  end

  // Load FSM: latches counts on start, walks the phases, holds everything while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt_bias   <= '0;
      cnt_weight <= '0;
      cnt_ifmap  <= '0;
      remaining  <= '0;
      addr_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt_bias   <= bus.cfg_bias_words;
            cnt_weight <= bus.cfg_weight_words;
            cnt_ifmap  <= bus.cfg_ifmap_words;
            state      <= first_phase;
            remaining  <= first_count;
            addr_cnt   <= '0;
          end
        end
        LD_BIAS, LD_WEIGHT, LD_IFMAP: begin
          if (xfer) begin
            if (last_word) begin
              // Next phase starts in the very next cycle, so no bubble between phases
              state     <= after_phase;
              remaining <= after_count;
              addr_cnt  <= '0;
            end else begin
              remaining <= remaining - (ADDR_W+1)'(1);
              addr_cnt  <= addr_cnt + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Registered write port: one-cycle delayed copy of each accepted word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias_wen_q   <= 1'b0;
      weight_wen_q <= 1'b0;
      ifmap_wen_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      bias_wen_q   <= xfer && (state == LD_BIAS);
      weight_wen_q <= xfer && (state == LD_WEIGHT);
      ifmap_wen_q  <= xfer && (state == LD_IFMAP);
      if (xfer) begin
        addr_q  <= addr_cnt;
        wdata_q <= bus.in_data;
      end
    end
  end

  assign bus.in_ready   = loading && !bus.hold;
  assign bus.bias_wen   = bias_wen_q;
  assign bus.weight_wen = weight_wen_q;
  assign bus.ifmap_wen  = ifmap_wen_q;
  assign bus.glb_addr   = addr_q;
  assign bus.glb_wdata  = wdata_q;
  assign bus.busy       = (state != IDLE);
  assign bus.load_done  = (state == DONE);

endmodule

// File: tb/tb_glb_load_scheduler.sv
// tb/tb_glb_load_scheduler.sv - self-checking bench for glb_load_scheduler
module tb_glb_load_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  glb_load_scheduler_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  glb_load_scheduler #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One expected GLB write: which buffer (bit0 bias, bit1 weight, bit2 ifmap) and address
  typedef struct {
    logic [2:0] sel;
    int         addr;
  } wr_t;

  wr_t         exp_q[$];
  int          compared = 0;
  int          mismatched = 0;
  int          n_wen;
  bit          m_loading;
  bit          m_done;
  bit          m_xfer;
  int          m_left;
  logic [2:0]  m_wen;
  logic [11:0] m_addr;
  logic [31:0] m_data;
  logic [31:0] data_ctr;
  int          t_basic, t_hold, t_sparse, t_skip, t_zero, t_restart, t_after_rst, t_rand;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_loading = 1'b0;
    m_done    = 1'b0;
    m_left    = 0;
    m_wen     = 3'b000;
    m_addr    = '0;
    m_data    = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_wen"}, {bus.ifmap_wen, bus.weight_wen, bus.bias_wen}, 0);
    chk({tag, "_addr"}, bus.glb_addr, 0);
    chk({tag, "_wdata"}, bus.glb_wdata, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_load_done"}, bus.load_done, 0);
  endtask

  // One clock cycle: drive at negedge, check ready, advance the model at posedge, check at negedge
  task automatic step(input bit s, input int cb, input int cw, input int ci,
                      input bit v, input bit h, input logic [31:0] d);
    bit  exp_ready;
    wr_t e;
    bus.start            = s;
    bus.cfg_bias_words   = 13'(cb);
    bus.cfg_weight_words = 13'(cw);
    bus.cfg_ifmap_words  = 13'(ci);
    bus.hold             = h;
    bus.in_valid         = v;
    bus.in_data          = d;
    #1;
    exp_ready = m_loading && !h;
    chk("in_ready", bus.in_ready, exp_ready);
    m_xfer = v && exp_ready;
    @(posedge clk);
    if (m_xfer) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transfer", 1, 0);
        m_wen = 3'b000;
      end else begin
        e      = exp_q.pop_front();
        m_wen  = e.sel;
        m_addr = e.addr[11:0];
        m_data = d;
      end
      m_left--;
      if (m_left == 0) begin
        m_loading = 1'b0;
        m_done    = 1'b1;
      end
    end else begin
      m_wen = 3'b000;
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_loading && s) begin
        for (int j = 0; j < cb; j++) exp_q.push_back('{sel: 3'b001, addr: j});
        for (int j = 0; j < cw; j++) exp_q.push_back('{sel: 3'b010, addr: j});
        for (int j = 0; j < ci; j++) exp_q.push_back('{sel: 3'b100, addr: j});
        m_left = cb + cw + ci;
        if (m_left == 0) m_done = 1'b1;
        else             m_loading = 1'b1;
      end
    end
    @(negedge clk);
    chk("wen", {bus.ifmap_wen, bus.weight_wen, bus.bias_wen}, m_wen);
    chk("glb_addr", bus.glb_addr, m_addr);
    chk("glb_wdata", bus.glb_wdata, m_data);
    chk("busy", bus.busy, m_loading || m_done);
    chk("load_done", bus.load_done, m_done);
    n_wen += int'(bus.bias_wen) + int'(bus.weight_wen) + int'(bus.ifmap_wen);
  endtask

  // vmode: 0 valid always, 1 valid toggling 1,0,1,0, 2 random valid/hold/data
  task automatic run_load(input int b, input int w, input int i, input int vmode,
                          input int hold_at, input int hold_len, input int restart_at,
                          input int abort_at, output int done_cyc);
    bit          v, h, s;
    logic [31:0] d;
    n_wen    = 0;
    data_ctr = 1;
    done_cyc = -1;
    step(1'b1, b, w, i, 1'b0, 1'b0, 32'h0);
    if (m_done) done_cyc = 0;
    for (int k = 1; done_cyc < 0 && k <= 300; k++) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (k % 2) == 1;
        default: v = $urandom_range(0, 3) != 0;
      endcase
      h = (k >= hold_at && k < hold_at + hold_len) ||
          (vmode == 2 && $urandom_range(0, 3) == 0);
      s = (k == restart_at);
      d = (vmode == 2) ? 32'($urandom) : data_ctr;
      step(s, 5, 4, 3, v, h, d);
      if (m_xfer) data_ctr++;
      if (k == abort_at) return;
      if (m_done) done_cyc = k;
    end
    if (done_cyc < 0) chk("load_timeout", 1, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("wen_count", n_wen, b + w + i);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int dummy;
    bus.start            = 1'b0;
    bus.cfg_bias_words   = '0;
    bus.cfg_weight_words = '0;
    bus.cfg_ifmap_words  = '0;
    bus.hold             = 1'b0;
    bus.in_valid         = 1'b0;
    bus.in_data          = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 32'h0);

    // Basic load 2/3/2 with data 1..7
    run_load(2, 3, 2, 0, 0, 0, 0, 0, t_basic);
    chk("basic_duration", t_basic, 7);

    // Three-cycle hold during the weight phase
    run_load(2, 3, 2, 0, 4, 3, 0, 0, t_hold);
    chk("hold_duration", t_hold, t_basic + 3);

    // Sparse source
    run_load(2, 3, 2, 1, 0, 0, 0, 0, t_sparse);
    chk("sparse_duration", t_sparse, 13);

    // Zero-count phases skipped
    run_load(0, 2, 0, 0, 0, 0, 0, 0, t_skip);
    chk("skip_duration", t_skip, 2);

    // All counts zero
    run_load(0, 0, 0, 0, 0, 0, 0, 0, t_zero);
    chk("zero_duration", t_zero, 0);

    // Start mid-load with other counts is ignored
    run_load(2, 3, 2, 0, 0, 0, 3, 0, t_restart);
    chk("restart_duration", t_restart, 7);

    // Reset during the weight phase
    run_load(2, 3, 2, 0, 0, 0, 0, 4, dummy);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_async");
    model_reset();
    @(negedge clk);
    chk_all_zero("rst_held");
    rst = 1'b1;
    step(1'b0, 0, 0, 0, 1'b1, 1'b0, 32'h55);
    run_load(1, 0, 0, 0, 0, 0, 0, 0, t_after_rst);
    chk("after_rst_duration", t_after_rst, 1);

    // Randomized loads
    for (int r = 0; r < 10; r++) begin
      run_load($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), 2,
               0, 0, $urandom_range(1, 8), 0, t_rand);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/glb_load_scheduler.md
# glb_load_scheduler

Sequences the single 32-bit DRAM input stream into the three global buffers (bias, weight, ifmap) before each layer's compute pass. It sits between the DRAM interface and the GLB SRAM write ports, generating per-buffer write enables and word addresses. It also yields the shared GLB port to the compute controller whenever `hold` is asserted. The compute controller starts compute only after `load_done`.

## Interface
Parameters:
- `ADDR_W`, 12, GLB word-address width.
- `DATA_W`, 32, stream and SRAM write-data width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle load request; ignored while `busy`=1.
- `cfg_bias_words` in ADDR_W+1: bias words to load; sampled on accepted `start`.
- `cfg_weight_words` in ADDR_W+1: weight words to load; sampled on accepted `start`.
- `cfg_ifmap_words` in ADDR_W+1: ifmap words to load; sampled on accepted `start`.
- `hold` in 1: compute owns the GLB port; stall loading.
- `in_valid` in 1: DRAM word available.
- `in_data` in DATA_W: DRAM word.
- `in_ready` out 1: scheduler accepts `in_data` this cycle.
- `bias_wen` out 1: bias SRAM write enable.
- `weight_wen` out 1: weight SRAM write enable.
- `ifmap_wen` out 1: ifmap SRAM write enable.
- `glb_addr` out ADDR_W: write word address.
- `glb_wdata` out DATA_W: write data.
- `busy` out 1: a load is in progress.
- `load_done` out 1: one-cycle pulse when the load completes.

## Operation
- FSM states: IDLE, LD_BIAS, LD_WEIGHT, LD_IFMAP, DONE. Fixed order: bias, then weight, then ifmap.
- IDLE + `start`:
  - Latch the three counts into count registers.
  - Go to the first phase with a nonzero count.
  - If all three counts are 0, go directly to DONE.
- Handshake: `in_ready` = (state is LD_*) && !`hold`. A transfer occurs when `in_valid` && `in_ready` in the same cycle.
- Per phase:
  - Address counter `addr_cnt` resets to 0 on phase entry.
  - `remaining` loads from the latched count on phase entry.
  - Each transfer increments `addr_cnt` (wraps at 2^ADDR_W; unreachable when counts are ≤ 2^ADDR_W) and decrements `remaining`.
- Phase exit: when a transfer occurs with `remaining`==1, move to the next phase with a nonzero count. If no such phase remains, go to DONE. Zero-count phases are skipped with no idle cycle.
- DONE: lasts exactly one cycle, then IDLE. `load_done`=1 and `busy`=1 during DONE.
- `busy` = state != IDLE.
- `hold` only gates `in_ready`. The FSM state and counters freeze while `hold`=1. A write already registered still completes.
- `start` while `busy`=1: ignored. Counts are not re-sampled.
- `in_valid` low or `hold` high: no write occurs and counters are unchanged.

## Timing
- Write path is registered, with one-cycle latency. On the cycle after a transfer:
  - exactly one of `*_wen`=1, selected by the phase in which the transfer occurred;
  - `glb_addr` = `addr_cnt` value at transfer;
  - `glb_wdata` = `in_data` at transfer.
- `*_wen` is 0 in every cycle not following a transfer. `glb_addr` and `glb_wdata` hold their last values when no write occurs.
- Last word: its `ifmap_wen` (or the `wen` of the last nonzero phase) appears in the same cycle as `load_done`.
- Throughput: one word per cycle with `in_valid`=1 and `hold`=0. There is no bubble between phases.
- Start latency: `in_ready` may rise the cycle after `start`. With all counts zero, `load_done` appears the cycle after `start`.
- Reset (async, `rst`=0) takes effect immediately, including mid-load:
  - state IDLE;
  - all counters 0;
  - `in_ready`, `*_wen`, `busy`, `load_done` = 0;
  - `glb_addr` = 0, `glb_wdata` = 0.
  
  Deassertion is synchronous to `clk`.
- Words transferred before reset are not replayed. A new `start` is required.

## Test plan
- Basic load: counts bias=2, weight=3, ifmap=2; `in_valid`=1 continuously; data 1..7.
  - Required writes, one per cycle starting the cycle after first `in_ready`: bias addr 0,1 (data 1,2); weight addr 0,1,2 (data 3,4,5); ifmap addr 0,1 (data 6,7).
  - `load_done` is coincident with the ifmap addr-1 write. `busy` falls the next cycle.
- Backpressure: same config as basic load; `hold`=1 for 3 cycles during the weight phase.
  - `in_ready`=0 for those 3 cycles and no `wen` follows them.
  - Weight addresses continue 0,1,2 with no gap or duplicate.
  - Total duration is 3 cycles longer than the basic load.
- Sparse source: `in_valid` toggles 1,0,1,0.
  - Writes occur only on cycles following a transfer.
  - Addresses remain contiguous.
  - Exactly 7 writes occur.
- Zero skip: bias=0, weight=2, ifmap=0. Required: two weight writes (addr 0,1), then `load_done`. No bias or ifmap `wen` ever asserts.
- All counts zero: `start` -> `load_done` pulse the next cycle; no `wen` asserts.
- Ignored start: `start` pulsed again mid-load with different counts. The load completes per the original counts.
- Reset mid-load: assert `rst`=0 during the weight phase.
  - All outputs are 0 immediately.
  - After release, a new `start` (bias=1) writes bias addr 0.
